wb_commit_queue: RTL and testbench

- Parametrised successor to the single-slot pass-through writeback stage.
- Sits between MEM/WB and the register file / difftest commit interface. Buffers up to DEPTH retired instructions in order.
- Writes the register file only when an entry commits, so architectural state stays in step with difftest.
- Exposes a commit counter and a two-port forwarding lookup over in-flight entries.

---
 rtl/wb_commit_queue.sv | 126 ++++++++++++
 tb/tb_wb_commit_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_queue.sv
// In-order writeback commit queue: buffers retired instructions, commits them
// one per cycle to the register file / difftest, and forwards in-flight results.
module wb_commit_queue #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INS_W  = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INS_W-1:0]  in_ins,
  input  logic              in_wen,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              cmt_valid,
  input  logic              cmt_ready,
  output logic [ADDR_W-1:0] cmt_pc,
  output logic [INS_W-1:0]  cmt_ins,
  output logic              cmt_wen,
  output logic [4:0]        cmt_rd,
  output logic [DATA_W-1:0] cmt_data,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [4:0]        fwd_rs1,
  input  logic [4:0]        fwd_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [63:0]       cmt_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
    logic              wen;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head_ent;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [63:0]       cnt_q;
  logic              push, pop;

  assign in_ready  = (count != FULL);
  assign cmt_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = cmt_valid && cmt_ready;

  assign head_ent  = cmt_valid ? mem[head] : '0;
  assign cmt_pc    = head_ent.pc;
  assign cmt_ins   = head_ent.ins;
  assign cmt_wen   = head_ent.wen;
  assign cmt_rd    = head_ent.rd;
  assign cmt_data  = head_ent.data;

  // x0 is hardwired zero, so rd=0 entries retire without touching the regfile.
  assign rf_wen    = pop && head_ent.wen && (head_ent.rd != 5'd0);
  assign rf_waddr  = rf_wen ? head_ent.rd   : 5'd0;
  assign rf_wdata  = rf_wen ? head_ent.data : '0;
  assign cmt_cnt   = cnt_q;

  // NOTE: entry storage has no reset; an entry is only observed while count
  // says it is live, so clearing it would cost flops for no behavioural gain.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{pc: in_pc, ins: in_ins, wen: in_wen, rd: in_rd, data: in_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      cnt_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head  <= head + 1'b1;
        cnt_q <= cnt_q + 64'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match written is the youngest one.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && mem[idx].wen) begin
        if ((fwd_rs1 != 5'd0) && (mem[idx].rd == fwd_rs1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem[idx].data;
        end
        if ((fwd_rs2 != 5'd0) && (mem[idx].rd == fwd_rs2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue: a queue-based reference model checked
// every cycle, plus hand-computed expectations at the key points.
module tb_wb_commit_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_ins = '0;
  logic        in_wen = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_data = '0;
  logic        cmt_valid, cmt_ready = 1'b0;
  logic [63:0] cmt_pc;
  logic [31:0] cmt_ins;
  logic        cmt_wen;
  logic [4:0]  cmt_rd;
  logic [63:0] cmt_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  fwd_rs1 = 5'd5, fwd_rs2 = 5'd7;
  logic        fwd_hit1, fwd_hit2;
  logic [63:0] fwd_data1, fwd_data2;
  logic [63:0] cmt_cnt;

  always #5 clk = ~clk;

  wb_commit_queue #(.ADDR_W(64), .DATA_W(64), .INS_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
    .in_wen(in_wen), .in_rd(in_rd), .in_data(in_data),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc), .cmt_ins(cmt_ins),
    .cmt_wen(cmt_wen), .cmt_rd(cmt_rd), .cmt_data(cmt_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .cmt_cnt(cmt_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of retired instructions and a commit tally.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_cnt = '0;
  bit          m_push, m_pop;
  ent_t        m_new;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_cnt = '0;
    end else begin
      m_push = in_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() != 0) && cmt_ready;
      if (m_pop) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 64'd1;
      end
      if (m_push) begin
        m_new.pc = in_pc; m_new.ins = in_ins; m_new.wen = in_wen;
        m_new.rd = in_rd; m_new.data = in_data;
        mq.push_back(m_new);
      end
    end
  end

  function automatic void lookup(input logic [4:0] rs, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].wen && mq[i].rd == rs) begin
          hit = 1'b1;
          d   = mq[i].data;
          break;
        end
      end
    end
  endfunction

  bit          cmp_en = 1'b0;
  ent_t        h;
  logic        e_valid, e_rf, e_hit1, e_hit2;
  logic [63:0] e_d1, e_d2;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_valid = (mq.size() != 0);
      if (e_valid) h = mq[0];
      else begin
        h.pc = '0; h.ins = '0; h.wen = 1'b0; h.rd = '0; h.data = '0;
      end
      e_rf = e_valid && cmt_ready && h.wen && (h.rd != 5'd0);
      lookup(fwd_rs1, e_hit1, e_d1);
      lookup(fwd_rs2, e_hit2, e_d2);
      check("in_ready",  in_ready,  mq.size() != DEPTH);
      check("cmt_valid", cmt_valid, e_valid);
      check("cmt_pc",    cmt_pc,    h.pc);
      check("cmt_ins",   cmt_ins,   h.ins);
      check("cmt_wen",   cmt_wen,   h.wen);
      check("cmt_rd",    cmt_rd,    h.rd);
      check("cmt_data",  cmt_data,  h.data);
      check("rf_wen",    rf_wen,    e_rf);
      check("rf_waddr",  rf_waddr,  e_rf ? h.rd : 5'd0);
      check("rf_wdata",  rf_wdata,  e_rf ? h.data : 64'd0);
      check("fwd_hit1",  fwd_hit1,  e_hit1);
      check("fwd_data1", fwd_data1, e_d1);
      check("fwd_hit2",  fwd_hit2,  e_hit2);
      check("fwd_data2", fwd_data2, e_d2);
      check("cmt_cnt",   cmt_cnt,   m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                        input logic wen, input logic [4:0] rd, input logic [63:0] data);
    in_valid = v; in_pc = pc; in_ins = ins; in_wen = wen; in_rd = rd; in_data = data;
  endtask

  initial begin
    #2;
    check("rst in_ready",  in_ready,  1'b1);
    check("rst cmt_valid", cmt_valid, 1'b0);
    check("rst rf_wen",    rf_wen,    1'b0);
    check("rst fwd_hit1",  fwd_hit1,  1'b0);
    check("rst cmt_pc",    cmt_pc,    64'd0);
    check("rst cmt_cnt",   cmt_cnt,   64'd0);
    tick(); tick();
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Single push with consumer ready: commits the following cycle.
    set_in(1'b1, 64'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 64'd5);
    cmt_ready = 1'b1;
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    check("t1 cmt_valid", cmt_valid, 1'b1);
    check("t1 rf_wen",    rf_wen,    1'b1);
    check("t1 rf_waddr",  rf_waddr,  5'd1);
    check("t1 rf_wdata",  rf_wdata,  64'd5);
    check("t1 cnt0",      cmt_cnt,   64'd0);
    tick(); #2;
    check("t1 cnt1",      cmt_cnt,   64'd1);
    check("t1 empty",     cmt_valid, 1'b0);

    // Fill to capacity with consumer stalled, then drain in order.
    cmt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h13, 1'b1, 5'(i + 1), 64'(100 + i));
      tick();
    end
    set_in(1'b1, 64'h8000_0010, 32'h13, 1'b1, 5'd9, 64'd104);
    #2;
    check("t2 full",       in_ready, 1'b0);
    tick(); tick(); #2;
    check("t2 stall rdy",  in_ready, 1'b0);
    check("t2 stall head", cmt_pc,   64'h8000_0000);
    cmt_ready = 1'b1;
    tick(); #2;
    check("t2 ready back", in_ready, 1'b1);
    check("t2 pc1",        cmt_pc,   64'h8000_0004);
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    check("t2 pc2", cmt_pc, 64'h8000_0008);
    tick(); #2;
    check("t2 pc3", cmt_pc, 64'h8000_000C);
    tick(); #2;
    check("t2 pc4", cmt_pc, 64'h8000_0010);
    tick(); #2;
    check("t2 drained", cmt_valid, 1'b0);
    check("t2 cnt",     cmt_cnt,   64'd6);

    // Steady push+pop at count 3 long enough to wrap both pointers.
    cmt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 64'h1000 + 64'(4 * i), 32'h33, 1'b1, 5'(i), 64'(i * 3));
      tick();
    end
    cmt_ready = 1'b1;
    for (int i = 3; i < 13; i++) begin
      set_in(1'b1, 64'h1000 + 64'(4 * i), 32'h33, 1'b1, 5'(i), 64'(i * 3));
      tick();
    end
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    check("t3 head pc",  cmt_pc,   64'h1028);
    check("t3 cnt",      cmt_cnt,  64'd16);
    check("t3 in_ready", in_ready, 1'b1);
    tick(); tick(); tick(); #2;
    check("t3 drained",  cmt_valid, 1'b0);
    check("t3 cnt end",  cmt_cnt,   64'd19);

    // Forwarding: youngest match wins, rd=0 and wen=0 entries never match.
    cmt_ready = 1'b0;
    fwd_rs1   = 5'd5;
    fwd_rs2   = 5'd0;
    set_in(1'b1, 64'h2000, 32'h1, 1'b1, 5'd5, 64'h11); tick();
    set_in(1'b1, 64'h2004, 32'h2, 1'b1, 5'd5, 64'h22); tick();
    set_in(1'b1, 64'h2008, 32'h3, 1'b1, 5'd0, 64'h33); tick();
    set_in(1'b1, 64'h200C, 32'h4, 1'b0, 5'd5, 64'h44); tick();
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    check("t4 hit1",  fwd_hit1,  1'b1);
    check("t4 data1", fwd_data1, 64'h22);
    check("t4 hit2",  fwd_hit2,  1'b0);
    check("t4 data2", fwd_data2, 64'h0);
    cmt_ready = 1'b1;
    tick(); #2;
    check("t4 hit1 after pop",  fwd_hit1,  1'b1);
    check("t4 data1 after pop", fwd_data1, 64'h22);
    tick(); #2;
    check("t4 rd0 head",   cmt_data, 64'h33);
    check("t4 rd0 rf_wen", rf_wen,   1'b0);
    check("t4 hit1 gone",  fwd_hit1, 1'b0);
    check("t4 cnt a",      cmt_cnt,  64'd21);
    tick(); #2;
    check("t4 cnt b",      cmt_cnt,  64'd22);
    check("t4 wen0 rf",    rf_wen,   1'b0);
    tick(); #2;
    check("t4 cnt c",      cmt_cnt,  64'd23);
    check("t4 empty",      cmt_valid, 1'b0);

    // Asynchronous reset mid-cycle with three entries queued.
    cmt_ready = 1'b0;
    fwd_rs2   = 5'd7;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 64'h3000 + 64'(4 * i), 32'h7, 1'b1, 5'd7, 64'h70 + 64'(i));
      tick();
    end
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    check("t5 queued",   cmt_valid, 1'b1);
    check("t5 hit2",     fwd_hit2,  1'b1);
    reset = 1'b0;
    #1;
    check("t5 rst valid", cmt_valid, 1'b0);
    check("t5 rst ready", in_ready,  1'b1);
    check("t5 rst cnt",   cmt_cnt,   64'd0);
    check("t5 rst hit2",  fwd_hit2,  1'b0);
    cmt_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      check("t5 no rf_wen", rf_wen,    1'b0);
      check("t5 empty",     cmt_valid, 1'b0);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
